// File: rtl/fir_mac_seq_if.sv
// fir_mac_seq_if: sample stream, coefficient port, multiplier port and status
// of the time-multiplexed FIR sequencer, grouped into one bundle.
//   master : the environment (sample source, coefficient writer, multiplier)
//   slave  : the fir_mac_seq block
// Signals:
//   in_valid/in_ready/in_data/flush    sample input handshake and delay-line flush
//   coef_we/coef_addr/coef_wdata       coefficient write port
//   mul_en/mul_a/mul_b/mul_p           shared fractional multiplier operands/product
//   out_valid/out_data/busy            filtered sample output and status
interface fir_mac_seq_if #(
  parameter int unsigned W    = 24,
  parameter int unsigned TAPS = 16
);
  localparam int unsigned AW = $clog2(TAPS);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          flush;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [W-1:0]  coef_wdata;
  logic          mul_en;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [W-1:0]  mul_p;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          busy;

  modport master (
    output in_valid, in_data, flush, coef_we, coef_addr, coef_wdata, mul_p,
    input  in_ready, mul_en, mul_a, mul_b, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, flush, coef_we, coef_addr, coef_wdata, mul_p,
    output in_ready, mul_en, mul_a, mul_b, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR sequencer. Each accepted Q1.23 sample is
// written into a circular delay line, then TAPS sample/coefficient pairs are
// streamed to an external fractional multiplier (fixed latency MUL_LAT) and the
// returned products are summed in a W+GUARD bit accumulator. The sum is reduced
// to W bits and emitted with a one-cycle out_valid pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    fir_mac_seq_if.slave (sample in, coefficient write, multiplier, result)
// Configuration macro:
//   FIR_SAT_EN  when defined, out_data clamps to 0x7FFFFF / 0x800000 on overflow;
//               when undefined, out_data is the low W bits of the accumulator.
module fir_mac_seq #(
  parameter int unsigned W       = 24,
  parameter int unsigned TAPS    = 16,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned GUARD   = 4
) (
  input  logic           clk,
  input  logic           reset,
  fir_mac_seq_if.slave   bus
);

  localparam int unsigned AW    = $clog2(TAPS);
  localparam int unsigned ACC_W = W + GUARD;
  localparam int unsigned DW    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      k_q, k_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               mul_en_q, mul_en_d;
  logic [W-1:0]       mul_a_q, mul_a_d;
  logic [W-1:0]       mul_b_q, mul_b_d;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       out_data_q, out_data_d;

  logic [W-1:0]       dline [TAPS];
  logic [W-1:0]       coef  [TAPS];

  logic               accept_c;
  logic               flush_c;
  logic [AW-1:0]      ptr_eff_c;
  logic [AW-1:0]      k_nxt_c;
  logic               prod_tag_c;
  logic [ACC_W-1:0]   prod_ext_c;
  logic [W-1:0]       quant_c;

  assign accept_c   = (state_q == IDLE) && bus.in_valid;
  assign flush_c    = (state_q == IDLE) && bus.flush;
  // A same-cycle flush moves the write slot to entry 0 before the sample lands.
  assign ptr_eff_c  = flush_c ? '0 : wr_ptr_q;
  assign k_nxt_c    = k_q + 1'b1;
  assign prod_tag_c = vld_q[MUL_LAT-1];
  assign prod_ext_c = {{GUARD{bus.mul_p[W-1]}}, bus.mul_p};

  // Reduce the accumulator to the Q1.23 output word.
`ifdef FIR_SAT_EN
  logic [GUARD:0] top_c;
  assign top_c = acc_q[ACC_W-1:W-1];

  always_comb begin
    quant_c = acc_q[W-1:0];
    if (!((top_c == '0) || (top_c == '1))) begin
      quant_c = acc_q[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign quant_c = acc_q[W-1:0];
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    drain_d     = drain_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    mul_en_d    = mul_en_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    // Valid tags follow the issued operands through the multiplier pipeline.
    vld_d       = (vld_q << 1) | MUL_LAT'(mul_en_q);

    if (((state_q == ISSUE) || (state_q == DRAIN)) && prod_tag_c) begin
      acc_d = acc_q + prod_ext_c;
    end

    unique case (state_q)
      IDLE: begin
        if (flush_c) begin
          wr_ptr_d = '0;
        end
        if (accept_c) begin
          state_d    = ISSUE;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          acc_d      = '0;
          k_d        = '0;
          wr_ptr_d   = ptr_eff_c + 1'b1;
          rd_ptr_d   = ptr_eff_c - 1'b1;
          // Tap 0 is the sample being written, so bypass the delay line.
          mul_en_d   = 1'b1;
          mul_a_d    = bus.in_data;
          mul_b_d    = coef[0];
        end
      end
      ISSUE: begin
        if (k_q == AW'(TAPS - 1)) begin
          state_d  = DRAIN;
          mul_en_d = 1'b0;
          drain_d  = '0;
        end else begin
          k_d      = k_nxt_c;
          rd_ptr_d = rd_ptr_q - 1'b1;
          mul_a_d  = dline[rd_ptr_q];
          mul_b_d  = coef[k_nxt_c];
        end
      end
      DRAIN: begin
        if (drain_q == DW'(MUL_LAT - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_data_d  = quant_c;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      drain_q     <= '0;
      acc_q       <= '0;
      vld_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      drain_q     <= drain_d;
      acc_q       <= acc_d;
      vld_q       <= vld_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      mul_en_q    <= mul_en_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Delay line and coefficient storage; both only change while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      if (flush_c) begin
        for (int unsigned i = 0; i < TAPS; i++) begin
          dline[i] <= '0;
        end
      end
      if (accept_c) begin
        dline[ptr_eff_c] <= bus.in_data;
      end
      if (bus.coef_we && (state_q == IDLE)) begin
        coef[bus.coef_addr] <= bus.coef_wdata;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.mul_en    = mul_en_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: self-checking bench for fir_mac_seq with a behavioural
// MUL_LAT-cycle Q1.23 multiplier and a reference FIR model feeding a scoreboard.
module tb_fir_mac_seq;
  localparam int unsigned W       = 24;
  localparam int unsigned TAPS    = 16;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned GUARD   = 4;
  localparam int unsigned AW      = $clog2(TAPS);
  localparam int unsigned ACC_W   = W + GUARD;
  localparam int          LAT     = TAPS + MUL_LAT + 1;

`ifdef FIR_SAT_EN
  localparam logic [W-1:0] SAT_POS_EXP = 24'h7FFFFF;
  localparam logic [W-1:0] SAT_NEG_EXP = 24'h800000;
`else
  localparam logic [W-1:0] SAT_POS_EXP = 24'hFFFFE0;
  localparam logic [W-1:0] SAT_NEG_EXP = 24'h000010;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  fir_mac_seq_if #(.W(W), .TAPS(TAPS)) bus ();

  fir_mac_seq #(.W(W), .TAPS(TAPS), .MUL_LAT(MUL_LAT), .GUARD(GUARD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mulfrac(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = (2*W)'($signed(a)) * (2*W)'($signed(b));
    return p[2*W-2:W-1];
  endfunction

  // Behavioural multiplier: product of the operands seen at an edge appears MUL_LAT edges later.
  logic [W-1:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mulfrac(bus.mul_a, bus.mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_p = mpipe[MUL_LAT-1];

  // Reference model and scoreboard.
  logic [W-1:0] m_hist [TAPS];
  logic [W-1:0] m_coef [TAPS];
  int           m_wr = 0;
  logic [W-1:0] exp_q [$];

  function automatic logic [W-1:0] model_out();
    logic signed [ACC_W-1:0] acc;
    longint a;
    int newest;
    acc = '0;
    newest = (m_wr + TAPS - 1) % TAPS;
    for (int k = 0; k < TAPS; k++)
      acc += ACC_W'($signed(mulfrac(m_hist[(newest - k + TAPS) % TAPS], m_coef[k])));
    a = acc;
`ifdef FIR_SAT_EN
    if (a > 64'sd8388607) return 24'h7FFFFF;
    if (a < -64'sd8388608) return 24'h800000;
`endif
    return acc[W-1:0];
  endfunction

  task automatic model_clear_hist();
    for (int i = 0; i < TAPS; i++) m_hist[i] = '0;
    m_wr = 0;
  endtask

  task automatic model_accept(input logic [W-1:0] d, input bit fl);
    if (fl) model_clear_hist();
    m_hist[m_wr] = d;
    m_wr = (m_wr + 1) % TAPS;
    exp_q.push_back(model_out());
  endtask

  // Stimulus helpers (no checking inside).
  task automatic write_coef(input int k, input logic [W-1:0] v);
    @(negedge clk);
    bus.coef_we = 1'b1; bus.coef_addr = AW'(k); bus.coef_wdata = v;
    @(negedge clk);
    bus.coef_we = 1'b0;
    m_coef[k] = v;
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    model_clear_hist();
  endtask

  task automatic send_start(input logic [W-1:0] d, input bit fl);
    @(negedge clk);
    for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.flush = fl;
    @(posedge clk);
    model_accept(d, fl);
    #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic [W-1:0] got, output bit to);
    to = 1'b1; lat = 0; got = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i; got = bus.out_data; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit fl, output int lat,
                      output logic [W-1:0] got, output bit to);
    send_start(d, fl);
    wait_out(lat, got, to);
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    n_cmp++; if (bus.mul_en !== 1'b0) begin n_err++; $display("FAIL reset_mul_en got=%b exp=0", bus.mul_en); end
    n_cmp++; if (bus.mul_a !== '0) begin n_err++; $display("FAIL reset_mul_a got=%h exp=0", bus.mul_a); end
    n_cmp++; if (bus.mul_b !== '0) begin n_err++; $display("FAIL reset_mul_b got=%h exp=0", bus.mul_b); end
  endtask

  task automatic test_single_tap();
    int lat; logic [W-1:0] got, exp; bit to;
    write_coef(0, 24'h200000);
    send(24'h400000, 1'b0, lat, got, to);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    n_cmp++; if (to || got !== exp) begin n_err++; $display("FAIL single_tap_sb got=%h exp=%h timeout=%0d", got, exp, to); end
    n_cmp++; if (got !== 24'h100000) begin n_err++; $display("FAIL single_tap_value got=%h exp=100000", got); end
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL single_tap_latency got=%0d exp=%0d", lat, LAT); end
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL single_tap_ready got=%b/%b exp=1/0", bus.in_ready, bus.busy); end
  endtask

  task automatic test_impulse();
    int lat; logic [W-1:0] got, exp, lit, d; bit to;
    do_flush();
    for (int k = 0; k < TAPS; k++) write_coef(k, W'(k * 32'h10000));
    for (int n = 0; n < 2 * TAPS + 1; n++) begin
      d = (n % TAPS == 0) ? 24'h7FFFFF : 24'h000000;
      lit = (n % TAPS == 0) ? 24'h000000 : W'((n % TAPS) * 32'h10000 - 1);
      send(d, 1'b0, lat, got, to);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      n_cmp++; if (to || got !== exp) begin n_err++; $display("FAIL impulse_sb n=%0d got=%h exp=%h", n, got, exp); end
      n_cmp++; if (got !== lit) begin n_err++; $display("FAIL impulse_value n=%0d got=%h exp=%h", n, got, lit); end
    end
  endtask

  task automatic test_saturation();
    int lat; logic [W-1:0] got, exp; bit to;
    do_flush();
    for (int k = 0; k < TAPS; k++) write_coef(k, 24'h7FFFFF);
    for (int n = 0; n < TAPS; n++) begin
      send(24'h7FFFFF, 1'b0, lat, got, to);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      n_cmp++; if (to || got !== exp) begin n_err++; $display("FAIL sat_pos_sb n=%0d got=%h exp=%h", n, got, exp); end
    end
    n_cmp++; if (got !== SAT_POS_EXP) begin n_err++; $display("FAIL sat_pos_final got=%h exp=%h", got, SAT_POS_EXP); end
    for (int n = 0; n < TAPS; n++) begin
      send(24'h800000, 1'b0, lat, got, to);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      n_cmp++; if (to || got !== exp) begin n_err++; $display("FAIL sat_neg_sb n=%0d got=%h exp=%h", n, got, exp); end
    end
    n_cmp++; if (got !== SAT_NEG_EXP) begin n_err++; $display("FAIL sat_neg_final got=%h exp=%h", got, SAT_NEG_EXP); end
  endtask

  task automatic test_backpressure();
    int outs, accn; logic rdy; logic [W-1:0] exp;
    outs = 0; accn = 0;
    write_coef(0, 24'h400000);
    write_coef(1, 24'h200000);
    for (int k = 2; k < TAPS; k++) write_coef(k, 24'h000000);
    for (int cyc = 0; cyc < 500 && outs < 4; cyc++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = W'(32'h010000 + cyc * 32'h123);
      n_cmp++; if (bus.in_ready !== !bus.busy) begin n_err++; $display("FAIL bp_ready_vs_busy cyc=%0d ready=%b busy=%b", cyc, bus.in_ready, bus.busy); end
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin model_accept(bus.in_data, 1'b0); accn++; end
      #1;
      if (bus.out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        n_cmp++; if (bus.out_data !== exp) begin n_err++; $display("FAIL bp_sb out=%0d got=%h exp=%h", outs, bus.out_data, exp); end
        outs++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (outs != 4 || accn != 4) begin n_err++; $display("FAIL bp_counts outs=%0d accepted=%0d exp=4/4", outs, accn); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_busy_write_flush();
    int lat; logic [W-1:0] got, exp; bit to;
    do_flush();
    write_coef(0, 24'h200000);
    write_coef(1, 24'h000000);
    send_start(24'h400000, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_during_issue got=%b exp=1", bus.busy); end
    bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_wdata = 24'h7FFFFF;
    @(negedge clk);
    bus.coef_we = 1'b0;
    wait_out(lat, got, to);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    n_cmp++; if (to || got !== exp) begin n_err++; $display("FAIL busy_write_first got=%h exp=%h", got, exp); end
    send(24'h400000, 1'b0, lat, got, to);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    n_cmp++; if (to || got !== exp) begin n_err++; $display("FAIL busy_write_sb got=%h exp=%h", got, exp); end
    n_cmp++; if (got !== 24'h100000) begin n_err++; $display("FAIL busy_write_dropped got=%h exp=100000", got); end
    write_coef(0, 24'h400000);
    write_coef(1, 24'h400000);
    do_flush();
    send(24'h400000, 1'b0, lat, got, to);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    n_cmp++; if (to || got !== exp || got !== 24'h200000) begin n_err++; $display("FAIL flush_then_sample got=%h exp=%h", got, exp); end
    send(24'h400000, 1'b1, lat, got, to);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    n_cmp++; if (to || got !== exp || got !== 24'h200000) begin n_err++; $display("FAIL flush_with_sample got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid_issue();
    int lat; logic [W-1:0] got, exp; bit to; bit seen;
    send_start(24'h7FFFFF, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.mul_en !== 1'b0) begin n_err++; $display("FAIL midreset_ctrl ready=%b busy=%b mul_en=%b exp=1/0/0", bus.in_ready, bus.busy, bus.mul_en); end
    n_cmp++; if (bus.mul_a !== '0 || bus.mul_b !== '0 || bus.out_data !== '0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_data a=%h b=%h out=%h ov=%b exp=0", bus.mul_a, bus.mul_b, bus.out_data, bus.out_valid); end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_clear_hist();
    for (int k = 0; k < TAPS; k++) m_coef[k] = '0;
    seen = 1'b0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL midreset_no_output got=1 exp=0"); end
    send(24'h400000, 1'b0, lat, got, to);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    n_cmp++; if (to || got !== exp || got !== 24'h000000) begin n_err++; $display("FAIL midreset_next got=%h exp=%h", got, exp); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
    for (int k = 0; k < TAPS; k++) m_coef[k] = '0;
    model_clear_hist();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_tap();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_busy_write_flush();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
